// File: rtl/async_fifo_pkg.sv
// Shared FIFO constants, pointer type and Gray/binary conversion helpers used by both
// pointer handlers of the 8-entry asynchronous FIFO.
package async_fifo_pkg;

    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned PTR_W      = 4;
    localparam int unsigned ADDR_W     = 3;

    typedef logic [PTR_W-1:0] gray_ptr_t;

    function automatic gray_ptr_t bin2gray(input logic [PTR_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [PTR_W-1:0] gray2bin(input gray_ptr_t gray);
        logic [PTR_W-1:0] bin;
        bin[PTR_W-1] = gray[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/read_pointer_handler_if.sv
// Consumer-facing and CDC-facing signals of the read pointer handler.
// The handler takes the slave modport; the consumer/testbench side takes master.
interface read_pointer_handler_if;
    import async_fifo_pkg::*;

    logic                  pop;
    gray_ptr_t             graycoded_write_pointer;
    logic                  empty;
    logic [ADDR_W-1:0]     read_pointer;
    gray_ptr_t             graycoded_read_pointer;
    logic [PTR_W-1:0]      fill_level;
    logic                  almost_empty;
    logic                  underflow;

    modport slave (
        input  pop,
        input  graycoded_write_pointer,
        output empty,
        output read_pointer,
        output graycoded_read_pointer,
        output fill_level,
        output almost_empty,
        output underflow
    );

    modport master (
        output pop,
        output graycoded_write_pointer,
        input  empty,
        input  read_pointer,
        input  graycoded_read_pointer,
        input  fill_level,
        input  almost_empty,
        input  underflow
    );

endinterface

// File: rtl/graycode_decoder_16.sv
// Combinational 4-bit Gray to binary decoder (16 codes).
module graycode_decoder_16
    import async_fifo_pkg::*;
(
    input  gray_ptr_t        gray_i,
    output logic [PTR_W-1:0] bin_o
);

    assign bin_o = gray2bin(gray_i);

endmodule

// File: rtl/graycode_encoder_16.sv
// Combinational 4-bit binary to Gray encoder (16 codes).
module graycode_encoder_16
    import async_fifo_pkg::*;
(
    input  logic [PTR_W-1:0] bin_i,
    output gray_ptr_t        gray_o
);

    assign gray_o = bin2gray(bin_i);

endmodule

// File: rtl/read_pointer_handler.sv
// Read-side pointer manager of the async FIFO: write-pointer synchronizer, read counter,
// empty/fill/almost-empty flags. Optional sticky underflow flag: ASYNC_FIFO_UNDERFLOW_CHK_EN.
module read_pointer_handler
    import async_fifo_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned AEMPTY_THRESH = 1
) (
    input  logic                     clk_rx,
    input  logic                     nrst_rx,
    read_pointer_handler_if.slave    rd_if
);

    logic [SYNC_STAGES-1:0][PTR_W-1:0] sync_q;
    gray_ptr_t                         synced_graycoded_write_pointer;
    logic [PTR_W-1:0]                  synced_write_bin;

    logic [PTR_W-1:0] read_counter_q, read_counter_d;
    gray_ptr_t        read_gray;
    gray_ptr_t        gray_read_ptr_q;

    logic             empty;
    logic             pop_accept;
    logic [PTR_W-1:0] fill_level;

    // Plain flop chain; nothing combinational between stages.
    always_ff @(posedge clk_rx or negedge nrst_rx) begin
        if (!nrst_rx) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= rd_if.graycoded_write_pointer;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign synced_graycoded_write_pointer = sync_q[SYNC_STAGES-1];

    graycode_encoder_16 u_read_encoder (
        .bin_i  (read_counter_q),
        .gray_o (read_gray)
    );

    graycode_decoder_16 u_write_decoder (
        .gray_i (synced_graycoded_write_pointer),
        .bin_o  (synced_write_bin)
    );

    always_comb begin
        empty          = (read_gray == synced_graycoded_write_pointer);
        pop_accept     = rd_if.pop & ~empty;
        read_counter_d = read_counter_q + PTR_W'(pop_accept);
        // Modulo-16 difference stays correct across counter wrap.
        fill_level     = synced_write_bin - read_counter_q;
    end

    always_ff @(posedge clk_rx or negedge nrst_rx) begin
        if (!nrst_rx) begin
            read_counter_q  <= '0;
            gray_read_ptr_q <= '0;
        end else begin
            read_counter_q  <= read_counter_d;
            gray_read_ptr_q <= read_gray;
        end
    end

`ifdef ASYNC_FIFO_UNDERFLOW_CHK_EN
    logic underflow_q;

    always_ff @(posedge clk_rx or negedge nrst_rx) begin
        if (!nrst_rx) begin
            underflow_q <= 1'b0;
        end else if (rd_if.pop && empty) begin
            underflow_q <= 1'b1;
        end
    end

    assign rd_if.underflow = underflow_q;
`else
    assign rd_if.underflow = 1'b0;
`endif

    assign rd_if.empty                  = empty;
    assign rd_if.read_pointer           = read_counter_q[ADDR_W-1:0];
    assign rd_if.graycoded_read_pointer = gray_read_ptr_q;
    assign rd_if.fill_level             = fill_level;
    assign rd_if.almost_empty           = (fill_level <= PTR_W'(AEMPTY_THRESH));

endmodule
